// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - ADC snapshot capture into SRAM and handshaked readout
//
// Purpose: stores cfg_len+1 decimated ADC samples into the capture SRAM, then
// replays them one at a time to the pad-side readout under valid/ready.
//
// Ports:
//   clk, rst_n            controller clock, asynchronous active-low reset
//   cfg_start/cfg_abort   one-cycle control pulses (abort has priority)
//   cfg_len, cfg_decim    samples-1 and keep-every-(decim+1), latched at start
//   cfg_rd_start          one-cycle pulse starting readout from CAP_DONE
//   adc_data, adc_vld     ADC sample bus
//   mem_*                 single-port SRAM, read data one cycle after select
//   out_data/valid/ready  readout stream
//   sts_*                 busy, sticky done flags, write count

module adc_capture_ctrl #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [3:0]        cfg_decim,
    input  logic              cfg_rd_start,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_vld,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sts_busy,
    output logic              sts_cap_done,
    output logic              sts_rd_done,
    output logic [ADDR_W:0]   sts_wr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_CAP_DONE, S_RD_ISSUE, S_RD_WAIT, S_RD_PRESENT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [3:0]          decim_q, decim_d;
    logic [3:0]          dc_q, dc_d;
    logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                cap_done_q, cap_done_d;
    logic                rd_done_q, rd_done_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        decim_d     = decim_q;
        dc_d        = dc_q;
        wr_cnt_d    = wr_cnt_q;
        rd_addr_d   = rd_addr_q;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cap_done_d  = cap_done_q;
        rd_done_d   = rd_done_q;

        if (cfg_abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        state_d    = S_CAPTURE;
                        cap_done_d = 1'b0;
                        rd_done_d  = 1'b0;
                        wr_cnt_d   = '0;
                        len_d      = cfg_len;
                        decim_d    = cfg_decim;
                        dc_d       = '0;
                    end
                end
                S_CAPTURE: begin
                    if (adc_vld) begin
                        dc_d = (dc_q == decim_q) ? 4'd0 : dc_q + 4'd1;
                        if (dc_q == 4'd0) begin
                            mem_cs_d    = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_cnt_q[ADDR_W-1:0];
                            mem_wdata_d = adc_data;
                            wr_cnt_d    = wr_cnt_q + (ADDR_W+1)'(1);
                            // wr_cnt never exceeds len while capturing, so the
                            // low bits suffice and the full-depth case stops
                            // before the address could wrap.
                            if (wr_cnt_q[ADDR_W-1:0] == len_q) begin
                                state_d    = S_CAP_DONE;
                                cap_done_d = 1'b1;
                            end
                        end
                    end
                end
                S_CAP_DONE: begin
                    // The read select is registered, so it is launched on
                    // entry to RD_ISSUE; data then returns during RD_WAIT.
                    if (cfg_rd_start) begin
                        rd_addr_d  = '0;
                        mem_cs_d   = 1'b1;
                        mem_addr_d = '0;
                        state_d    = S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    state_d = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    out_data_d  = mem_rdata;
                    out_valid_d = 1'b1;
                    state_d     = S_RD_PRESENT;
                end
                S_RD_PRESENT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (rd_addr_q == len_q) begin
                            rd_done_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            rd_addr_d  = rd_addr_q + ADDR_W'(1);
                            mem_cs_d   = 1'b1;
                            mem_addr_d = rd_addr_q + ADDR_W'(1);
                            state_d    = S_RD_ISSUE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            decim_q     <= '0;
            dc_q        <= '0;
            wr_cnt_q    <= '0;
            rd_addr_q   <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cap_done_q  <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            decim_q     <= decim_d;
            dc_q        <= dc_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_addr_q   <= rd_addr_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cap_done_q  <= cap_done_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign mem_cs       = mem_cs_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign sts_busy     = (state_q != S_IDLE);
    assign sts_cap_done = cap_done_q;
    assign sts_rd_done  = rd_done_q;
    assign sts_wr_cnt   = wr_cnt_q;

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sequences one ADC snapshot: writes a programmed number of ADC samples into the capture SRAM, then reads them out to the pad-side readout interface under a valid/ready handshake.
- Sits inside DIGITAL_WRAPPER, between the ADC sample bus (18-bit data plus data-valid), the single-port capture SRAM and the readout pad logic.
- Configuration and status are carried by MDIO register bits.

Parameters:
- DATA_W, 18, ADC sample width.
- ADDR_W, 14, SRAM address width; capture depth is up to 2^ADDR_W samples.

Ports:
- clk  in  1  controller clock, the same domain as the ADC sample bus and the SRAM.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse that starts a capture.
- cfg_abort  in  1  one-cycle pulse that aborts any operation.
- cfg_len  in  ADDR_W  number of samples minus 1.
- cfg_decim  in  4  keep every (cfg_decim+1)-th valid sample.
- cfg_rd_start  in  1  one-cycle pulse that starts readout after capture.
- adc_data  in  DATA_W  ADC sample.
- adc_vld  in  1  ADC sample qualifier.
- mem_cs  out  1  SRAM select.
- mem_we  out  1  SRAM write enable (1 = write).
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read select.
- out_data  out  DATA_W  readout sample.
- out_valid  out  1  readout sample valid.
- out_ready  in  1  readout sink ready.
- sts_busy  out  1  high in CAPTURE, CAP_DONE or READOUT.
- sts_cap_done  out  1  sticky: capture complete.
- sts_rd_done  out  1  sticky: readout complete.
- sts_wr_cnt  out  ADDR_W+1  samples written in the current capture.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset asserted mid-operation returns to IDLE immediately; SRAM contents are not cleared.
- States: IDLE, CAPTURE, CAP_DONE, RD_ISSUE, RD_WAIT, RD_PRESENT.
- cfg_abort:
  - From any state, go to IDLE on the next clock.
  - mem_cs and out_valid drop in that same cycle.
  - Sticky done flags are left unchanged.
  - If cfg_abort and cfg_start arrive in the same cycle, abort wins and the state stays IDLE.
- IDLE + cfg_start:
  - Go to CAPTURE.
  - Clear sts_cap_done, sts_rd_done and sts_wr_cnt.
  - Latch cfg_len and cfg_decim; later changes are ignored until the next start.
- cfg_start outside IDLE is ignored. cfg_rd_start outside CAP_DONE is ignored.
- CAPTURE:
  - A decimation counter dc counts adc_vld cycles, starting at 0.
  - A sample is kept when adc_vld=1 and dc==0; dc then counts up to decim and wraps to 0.
  - Cycles with adc_vld=0 do not advance dc.
  - For each kept sample, in the same cycle:
    - mem_cs=1, mem_we=1, mem_addr=wr_cnt[ADDR_W-1:0], mem_wdata=adc_data. These are registered outputs, so they appear one clk after the sample is accepted.
    - wr_cnt increments.
  - When the kept sample is number cfg_len (0-based), go to CAP_DONE and set sts_cap_done=1.
  - cfg_len = 2^ADDR_W-1 fills the whole SRAM; addresses never wrap.
- CAP_DONE: waits for cfg_rd_start, then sets rd_addr=0 and goes to RD_ISSUE.
- RD_ISSUE: mem_cs=1, mem_we=0, mem_addr=rd_addr; go to RD_WAIT.
- RD_WAIT: capture mem_rdata into out_data; set out_valid=1; go to RD_PRESENT.
- RD_PRESENT:
  - out_data and out_valid are held stable until out_ready=1.
  - On the handshake, drop out_valid next cycle.
  - If rd_addr == latched len: set sts_rd_done=1 and go to IDLE.
  - Otherwise: increment rd_addr and go to RD_ISSUE.
  - Throughput is at most 1 sample per 3 clk; the sink can stall indefinitely.
- mem_cs is a single-cycle pulse per access. mem_we=0 whenever mem_cs=0.
- sts_busy = state is not IDLE.
- sts_wr_cnt holds its final value until the next start.

Test Plan:
- Basic capture and readout: cfg_len=3, cfg_decim=0, adc_vld continuous with data 0x00001..0x00005. Required: 4 SRAM writes of 1..4 at addresses 0..3, sts_cap_done=1, sts_wr_cnt=4. After cfg_rd_start with out_ready=1: out_data sequence 1,2,3,4, then sts_rd_done=1, sts_busy=0.
- Decimation: cfg_decim=2, cfg_len=2, adc_vld on every cycle with data 10..20. Required: written data 10,13,16. Repeat with adc_vld toggling; required: only valid samples are counted.
- Backpressure: during readout, hold out_ready=0 for 7 cycles. Required: out_valid and out_data are stable for the whole stall, and no further mem_cs pulses occur.
- Abort: cfg_abort at the second sample of capture. Required: IDLE next cycle, sts_cap_done=0. Repeat with cfg_abort in RD_PRESENT; required: out_valid drops, sts_rd_done=0. Repeat with cfg_abort and cfg_start in the same cycle; required: the state stays IDLE.
- Ignored pulses: cfg_start during CAPTURE and cfg_rd_start during IDLE. Required: no state change, and the write count is unaffected.
- Full depth and reset: with ADDR_W=4 and cfg_len=15, required: addresses 0..15 are written and there is no wrap. Then assert rst_n=0 mid-readout; required: all outputs 0 immediately.
